// File: rtl/display_7seg_scan.sv
// Four-digit common-anode 7-segment scanner for the HH.MM clock display.
// Digits are snapshotted once per frame; guard cycles between digits suppress ghosting.
//
// state | meaning
// DIG0  | min_u selected,  an = 1110
// DIG1  | min_d selected,  an = 1101
// DIG2  | hora_u selected, an = 1011 (separator dot lives here)
// DIG3  | hora_d selected, an = 0111 (leading-zero blank)
module display_7seg_scan #(
  parameter int DIGIT_TICKS  = 2500,
  parameter int GUARD_TICKS  = 16,
  parameter int BLINK_FRAMES = 50,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hora_d,
  input  logic [3:0] hora_u,
  input  logic [3:0] min_d,
  input  logic [3:0] min_u,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] GUARD_END  = TW'(GUARD_TICKS);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_t;

  state_t        state, state_next;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          primed;
  logic          frame_end;
  logic          load;
  logic [3:0]    sh_hora_d, sh_hora_u, sh_min_d, sh_min_u;
  logic [FW-1:0] frame_cnt;
  logic          blink;

  logic          guard;
  logic [3:0]    digit;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign tick      = (tick_cnt == TICK_LAST);
  assign frame_end = tick && (state == DIG3);
  assign load      = !primed || frame_end;
  assign guard     = (tick_cnt < GUARD_END);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= DIG0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    an_next    = 4'b1111;
    digit      = sh_min_u;
    dp_next    = 1'b1;
    case (state)
      DIG0: begin
        digit   = sh_min_u;
        an_next = 4'b1110;
        if (tick) state_next = DIG1;
      end
      DIG1: begin
        digit   = sh_min_d;
        an_next = 4'b1101;
        if (tick) state_next = DIG2;
      end
      DIG2: begin
        digit   = sh_hora_u;
        an_next = 4'b1011;
        dp_next = !blink;
        if (tick) state_next = DIG3;
      end
      DIG3: begin
        digit   = sh_hora_d;
        an_next = (LZ_BLANK && (sh_hora_d == 4'd0)) ? 4'b1111 : 4'b0111;
        if (tick) state_next = DIG0;
      end
      default: state_next = DIG0;
    endcase
    if (guard) begin
      an_next = 4'b1111;
      dp_next = 1'b1;
    end
  end

  // Non-BCD codes render as a dash so a corrupted counter is visible.
  always_comb begin
    seg_next = 7'b0111111;
    case (digit)
      4'd0: seg_next = 7'b1000000;
      4'd1: seg_next = 7'b1111001;
      4'd2: seg_next = 7'b0100100;
      4'd3: seg_next = 7'b0110000;
      4'd4: seg_next = 7'b0011001;
      4'd5: seg_next = 7'b0010010;
      4'd6: seg_next = 7'b0000010;
      4'd7: seg_next = 7'b1111000;
      4'd8: seg_next = 7'b0000000;
      4'd9: seg_next = 7'b0010000;
      default: seg_next = 7'b0111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      primed      <= 1'b0;
      frame_start <= 1'b0;
      sh_hora_d   <= '0;
      sh_hora_u   <= '0;
      sh_min_d    <= '0;
      sh_min_u    <= '0;
    end else begin
      primed      <= 1'b1;
      frame_start <= load;
      if (load) begin
        sh_hora_d <= hora_d;
        sh_hora_u <= hora_u;
        sh_min_d  <= min_d;
        sh_min_u  <= min_u;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        blink     <= !blink;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_display_7seg_scan.sv
// Bench for display_7seg_scan: a cycle-position model (digit/offset/frame derived
// from the count of released clock edges) plus directed literal expectations.
module tb_display_7seg_scan;
  localparam int DT = 8;
  localparam int GT = 2;
  localparam int BF = 2;
  localparam int FRAME = DT * 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] hora_d, hora_u, min_d, min_u;
  logic [3:0] an, an_n;
  logic [6:0] seg, seg_n;
  logic       dp, dp_n, fs, fs_n;

  always #5 clk = ~clk;

  display_7seg_scan #(.DIGIT_TICKS(DT), .GUARD_TICKS(GT), .BLINK_FRAMES(BF), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .reset(reset), .hora_d(hora_d), .hora_u(hora_u), .min_d(min_d), .min_u(min_u),
    .an(an), .seg(seg), .dp(dp), .frame_start(fs));

  display_7seg_scan #(.DIGIT_TICKS(DT), .GUARD_TICKS(GT), .BLINK_FRAMES(BF), .LZ_BLANK(1'b0)) dut_nlz (
    .clk(clk), .reset(reset), .hora_d(hora_d), .hora_u(hora_u), .min_d(min_d), .min_u(min_u),
    .an(an_n), .seg(seg_n), .dp(dp_n), .frame_start(fs_n));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                               7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  // n = released clock edges since the last reset; outputs after edge n describe position n-1.
  int         n = 0;
  int         m, d, off, f;
  logic [3:0] snap [4];
  logic [3:0] v;
  logic       grd, bl, in_rst;
  logic [3:0] e_an, e_an_n;
  logic [6:0] e_seg;
  logic       e_dp, e_fs;

  always @(posedge clk) begin
    if (!reset) begin
      n = 0;
      snap = '{4'd0, 4'd0, 4'd0, 4'd0};
      in_rst = 1'b1;
      e_an = 4'hf; e_an_n = 4'hf; e_seg = 7'h7f; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      in_rst = 1'b0;
      n++;
      m   = n - 1;
      d   = (m / DT) % 4;
      off = m % DT;
      f   = m / FRAME;
      v   = snap[d];
      grd = (off < GT);
      bl  = ((f / BF) % 2) == 1;
      e_an_n = grd ? 4'hf : ~(4'b0001 << d);
      e_an   = (d == 3 && v == 4'd0) ? 4'hf : e_an_n;
      e_seg  = seg_tab[v];
      e_dp   = !(d == 2 && !grd && bl);
      e_fs   = (n == 1) || (n % FRAME == 0);
      if (e_fs) snap = '{min_u, min_d, hora_u, hora_d};
    end
    #1;
    chk("an", {28'd0, an}, {28'd0, e_an});
    chk("an_nlz", {28'd0, an_n}, {28'd0, e_an_n});
    chk("dp", {31'd0, dp}, {31'd0, e_dp});
    chk("dp_nlz", {31'd0, dp_n}, {31'd0, e_dp});
    chk("frame_start", {31'd0, fs}, {31'd0, e_fs});
    chk("frame_start_nlz", {31'd0, fs_n}, {31'd0, e_fs});
    if (in_rst || e_an != 4'hf) chk("seg", {25'd0, seg}, {25'd0, e_seg});
    if (in_rst || e_an_n != 4'hf) chk("seg_nlz", {25'd0, seg_n}, {25'd0, e_seg});
  end

  task automatic wait_n(input int target);
    int budget = 1000;
    while (n != target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (n != target) begin
      checks++;
      $display("FAIL wait_n: reached n=%0d, required %0d", n, target);
    end
  endtask

  task automatic lit(input string name, input logic [3:0] ea, input logic [6:0] es);
    chk({name, "_an"}, {28'd0, an}, {28'd0, ea});
    chk({name, "_seg"}, {25'd0, seg}, {25'd0, es});
  endtask

  initial begin
    hora_d = 4'd1; hora_u = 4'd2; min_d = 4'd3; min_u = 4'd4;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    lit("reset", 4'b1111, 7'b1111111);
    chk("reset_dp", {31'd0, dp}, 32'd1);
    chk("reset_fs", {31'd0, fs}, 32'd0);
    reset = 1'b1;

    wait_n(1);  chk("first_fs", {31'd0, fs}, 32'd1);
    wait_n(2);  chk("guard_an", {28'd0, an}, 32'hf);
    wait_n(3);  lit("dig0", 4'b1110, 7'b0011001);
    wait_n(11); lit("dig1", 4'b1101, 7'b0110000);
    wait_n(12); min_u = 4'd5;
    wait_n(19); lit("dig2", 4'b1011, 7'b0100100);
    wait_n(27); lit("dig3", 4'b0111, 7'b1111001);
    wait_n(32); chk("frame1_fs", {31'd0, fs}, 32'd1);
    wait_n(35); lit("new_min_u", 4'b1110, 7'b0010010);
    wait_n(36); min_d = 4'hc;
    wait_n(43); lit("hold_min_d", 4'b1101, 7'b0110000);
    wait_n(75); lit("dash_min_d", 4'b1101, 7'b0111111);
    wait_n(83); chk("blink_on_f2", {31'd0, dp}, 32'd0);
    wait_n(84); hora_d = 4'd0;
    wait_n(91); lit("hold_hora_d", 4'b0111, 7'b1111001);
    wait_n(115); chk("blink_on_f3", {31'd0, dp}, 32'd0);
    wait_n(123);
    chk("lz_blank_an", {28'd0, an}, 32'hf);
    chk("nlz_an", {28'd0, an_n}, {28'd0, 4'b0111});
    chk("nlz_seg", {25'd0, seg_n}, {25'd0, 7'b1000000});
    wait_n(147); chk("blink_off_f4", {31'd0, dp}, 32'd1);
    wait_n(180); reset = 1'b0;
    @(negedge clk);
    lit("midreset", 4'b1111, 7'b1111111);
    chk("midreset_dp", {31'd0, dp}, 32'd1);
    reset = 1'b1;
    wait_n(1); chk("rerelease_fs", {31'd0, fs}, 32'd1);
    wait_n(3); lit("restart_dig0", 4'b1110, 7'b0010010);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
